// File: rtl/mux_sched_pkg.sv
// Shared constants, state encoding and one-hot helper for mux_sel_scheduler.
package mux_sched_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_CH-1:0] sel2onehot(input logic [SEL_W-1:0] s);
    return N_CH'(1) << s;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr+1, wrapping.
module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // i = 4 wraps back to ptr itself, so the last-served channel is considered last
    for (int i = 1; i <= N_CH; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin burst scheduler driving the select of a downstream 4:1 mux.
// Optional MUX_SEL_SCHEDULER_LOCK_EN adds a lock input that holds the grant past its burst.
//
//   state | meaning
//   IDLE  | no valid selection, grant = 0, sel holds last value
//   GRANT | sel/grant valid, counting transfers toward BURST_LEN
module mux_sel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
`ifdef MUX_SEL_SCHEDULER_LOCK_EN
  input  logic             lock,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             sel_valid
);

  localparam logic [CNT_W:0]   LEN_C = (CNT_W+1)'(BURST_LEN);
  localparam logic [CNT_W-1:0] SAT_C = (BURST_LEN > 15) ? CNT_W'(15) : CNT_W'(BURST_LEN);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             armed_q;

  logic             xfer, req_hit, burst_end, release_g;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic [N_CH-1:0]  pick_req;
  logic [SEL_W-1:0] pick_ptr, pick_idx;
  logic             pick_found;

  assign xfer    = (state_q == GRANT) && out_ready;
  assign req_hit = req[sel_q];
  assign cnt_inc = {1'b0, burst_cnt_q} + (CNT_W+1)'(1);

`ifdef MUX_SEL_SCHEDULER_LOCK_EN
  assign burst_end = xfer && !lock && (cnt_inc >= LEN_C);
  assign cnt_next  = (burst_cnt_q >= SAT_C) ? SAT_C : cnt_inc[CNT_W-1:0];
`else
  assign burst_end = xfer && (cnt_inc >= LEN_C);
  assign cnt_next  = cnt_inc[CNT_W-1:0];
`endif

  assign release_g = (state_q == GRANT) && (burst_end || !req_hit);
  assign pick_req  = ((state_q == GRANT) && !req_hit) ? (req & ~sel2onehot(sel_q)) : req;
  assign pick_ptr  = (state_q == GRANT) ? sel_q : last_ptr_q;

  // Single picker shared by idle arbitration and release re-arbitration
  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    last_ptr_d  = last_ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (armed_q && pick_found) begin
          state_d     = GRANT;
          sel_d       = pick_idx;
          grant_d     = sel2onehot(pick_idx);
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_g) begin
          last_ptr_d  = sel_q;
          burst_cnt_d = '0;
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = sel2onehot(pick_idx);
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (xfer) begin
          burst_cnt_d = cnt_next;
        end
      end
    endcase
  end

  // armed_q delays the first arbitration to the second edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      last_ptr_q  <= 2'b11;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      last_ptr_q  <= last_ptr_d;
      armed_q     <= 1'b1;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign sel_valid = (state_q == GRANT);

endmodule

// File: doc/mux_sel_scheduler.md
MUX_SEL_SCHEDULER -- requirements
Module: mux_sel_scheduler

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, meaning accepted transfers per grant before rotation (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 4, per-channel request for channels 0..3.
REQ-005 The block SHALL have port out_ready, input, 1, downstream accepts the current selection this cycle.
REQ-006 The block SHALL have port sel, output, 2, registered select code that drives S of the downstream 4:1 mux.
REQ-007 The block SHALL have port grant, output, 4, registered one-hot copy of sel, and all-zero when idle.
REQ-008 The block SHALL have port sel_valid, output, 1, registered flag meaning sel/grant are valid.

Function
REQ-009 The FSM SHALL have exactly two states, IDLE (sel_valid=0) and GRANT (sel_valid=1).
REQ-010 A transfer SHALL occur on any cycle with sel_valid=1 and out_ready=1.
REQ-011 In IDLE with req!=0, the block SHALL pick the first set req bit, scanning upward modulo 4 from last_ptr+1, and enter GRANT on the next edge (1-cycle latency).
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with grant=0 and sel held.
REQ-013 In GRANT, sel and grant SHALL stay stable while out_ready=0 and req[sel]=1.
REQ-014 A 4-bit burst_cnt SHALL increment on each transfer and clear on every new grant.
REQ-015 A grant SHALL release on a transfer that makes burst_cnt reach BURST_LEN, or on any cycle in which req[sel]=0.
REQ-016 On release, last_ptr SHALL take the value of sel.
REQ-017 On release, the block SHALL re-arbitrate in the same cycle using the current req with the granted bit masked when req[sel]=0.
REQ-018 If the release re-arbitration finds a winner, the next edge SHALL load the new grant with no idle bubble; otherwise the block SHALL go to IDLE.
REQ-019 A lone requester that still holds req after its burst completes SHALL be re-granted back-to-back, and burst_cnt SHALL restart at 0.
REQ-020 grant SHALL always equal the one-hot decode of sel whenever sel_valid=1.

Reset
REQ-021 Asserting rst_n low SHALL immediately force state=IDLE, sel=2'b00, grant=4'b0000, sel_valid=0, burst_cnt=0 and last_ptr=2'b11, so the first arbitration favours channel 0.
REQ-022 Reset asserted mid-burst SHALL abandon the burst without completing any pending transfer.
REQ-023 After rst_n deasserts, the first grant SHALL appear no earlier than the second rising edge.

Configuration
REQ-024 The macro MUX_SEL_SCHEDULER_LOCK_EN SHALL control a lock feature.
REQ-025 With MUX_SEL_SCHEDULER_LOCK_EN defined, the block SHALL add input lock (1 bit).
REQ-026 With the lock feature built in, lock=1 in GRANT SHALL suppress the burst-count release, so the grant holds while req[sel]=1.
REQ-027 With the lock feature built in, burst_cnt SHALL saturate at BURST_LEN and SHALL not wrap.
REQ-028 With the lock feature built in, dropping req[sel] SHALL still release the grant.
REQ-029 Without MUX_SEL_SCHEDULER_LOCK_EN, the lock port SHALL be absent and the behaviour SHALL be exactly REQ-009..REQ-020.

Structure
REQ-030 Shared package mux_sched_pkg SHALL hold N_CH=4, SEL_W=2, CNT_W=4 and the state enum {IDLE, GRANT}.
REQ-031 Sub-module rr_pick4 SHALL be purely combinational, with inputs req[3:0] and ptr[1:0] and outputs found and idx[1:0].
REQ-032 rr_pick4 SHALL be instantiated once and shared by the idle and release arbitration paths.

Verification
REQ-033 Reset then req=4'b0001 with out_ready=1 held: sel_valid rises 1 cycle later with sel=0 and grant=0001; after 4 transfers the same channel is re-granted with no bubble.
REQ-034 req=4'b1111 with out_ready=1 and BURST_LEN=4: the grant order is 0,1,2,3,0, each for exactly 4 transfers, with sel_valid never low.
REQ-035 Granted channel 2 with out_ready=0 for 5 cycles: sel=2 and grant=0100 stay stable and burst_cnt stays 0.
REQ-036 Channel 1 granted with req=4'b1010, then req[1] drops mid-burst: the next edge grants channel 3.
REQ-037 rst_n pulsed low mid-burst on channel 3: the outputs return to 0 asynchronously, and with req=1111 the next grant is channel 0.
REQ-038 With MUX_SEL_SCHEDULER_LOCK_EN defined, lock=1 and req=1111: channel 0 holds for 10 transfers, and on lock=0 it releases at the next transfer and channel 1 is granted.
